// File: rtl/pbit_mul_scheduler.sv
// Shares one p-bit multiplier between two requesters: arbitrate, issue, wait, settle, sample, reply.
// Define PBIT_SCHED_VOTE_EN for a per-bit majority vote over the sample window.
module pbit_mul_scheduler #(
  parameter int unsigned P2       = 3,
  parameter int unsigned P3       = 1,
  parameter int unsigned SETTLE_W = 8,
  parameter int unsigned WINDOW   = 16,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                req0_valid,
  input  logic                req1_valid,
  output logic                req0_ready,
  output logic                req1_ready,
  input  logic                req0_mode,
  input  logic                req1_mode,
  input  logic [P2:0]         req0_bits,
  input  logic [P2:0]         req1_bits,
  input  logic [SETTLE_W-1:0] cfg_settle,
  output logic                rsp_valid,
  output logic                rsp_id,
  output logic [P2:0]         rsp_data,
  output logic                rsp_timeout,
  output logic                mul_mode,
  output logic                mul_valid_in,
  output logic [P3:0]         mul_in1,
  output logic [P3:0]         mul_in2,
  output logic [P2:0]         mul_op,
  input  logic [P2:0]         mul_res,
  input  logic                mul_valid_res
);

  localparam int unsigned SettleMax = (32'd1 << SETTLE_W) - 32'd1;
  localparam int unsigned CntMax0   = (TIMEOUT > SettleMax) ? TIMEOUT : SettleMax;
  localparam int unsigned CntMax    = (CntMax0 > WINDOW) ? CntMax0 : WINDOW;
  localparam int unsigned CntW      = $clog2(CntMax + 1);

  typedef enum logic [2:0] {StIdle, StIssue, StWait, StSettle, StSample, StDone} state_e;

  state_e              state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic                last_grant_q;
  logic                mode_q;
  logic [P2:0]         bits_q;
  logic [SETTLE_W-1:0] settle_q;
  logic                id_q;
  logic                to_q;
  logic                grant0, grant1, hs, timeout_hit, busy;
  logic [P2:0]         result;

  // Round-robin: on contention the requester not granted last time wins.
  assign grant0 = req0_valid && (!req1_valid || last_grant_q);
  assign grant1 = req1_valid && (!req0_valid || !last_grant_q);
  assign hs     = (state_q == StIdle) && (grant0 || grant1);

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      last_grant_q <= 1'b1;
      mode_q       <= 1'b0;
      bits_q       <= '0;
      settle_q     <= '0;
      id_q         <= 1'b0;
      to_q         <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (hs) begin
        last_grant_q <= grant1;
        id_q         <= grant1;
        mode_q       <= grant1 ? req1_mode : req0_mode;
        bits_q       <= grant1 ? req1_bits : req0_bits;
        settle_q     <= cfg_settle;
        to_q         <= 1'b0;
      end
      if (timeout_hit) begin
        to_q <= 1'b1;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    timeout_hit = 1'b0;
    case (state_q)
      StIdle:   if (hs) state_d = StIssue;
      StIssue:  state_d = StWait;
      StWait: begin
        if (mul_valid_res) begin
          state_d = (settle_q == '0) ? StSample : StSettle;
        end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
          state_d     = StDone;
          timeout_hit = 1'b1;
        end
      end
      StSettle: if (cnt_q == CntW'(settle_q) - CntW'(1)) state_d = StSample;
      StSample: if (cnt_q == CntW'(WINDOW - 1)) state_d = StDone;
      StDone:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Counter restarts at zero on every state entry; bounded per state so it never wraps.
  always_comb begin
    cnt_d = cnt_q + CntW'(1);
    if ((state_d != state_q) || (state_q == StIdle)) begin
      cnt_d = '0;
    end
  end

`ifdef PBIT_SCHED_VOTE_EN
  localparam int unsigned VoteW = $clog2(WINDOW + 1);
  logic [VoteW-1:0] ones_q [P2+1];

  always_ff @(posedge CLK) begin
    for (int i = 0; i <= int'(P2); i++) begin
      if (!RST || (state_q == StIssue)) begin
        ones_q[i] <= '0;
      end else if (state_q == StSample) begin
        ones_q[i] <= ones_q[i] + VoteW'(mul_res[i]);
      end
    end
  end

  // Strict majority; an exact tie resolves to 0.
  always_comb begin
    result = '0;
    for (int i = 0; i <= int'(P2); i++) begin
      result[i] = ((32'(ones_q[i]) << 1) > WINDOW);
    end
  end
`else
  logic [P2:0] last_q;

  always_ff @(posedge CLK) begin
    if (!RST) begin
      last_q <= '0;
    end else if (state_q == StSample) begin
      last_q <= mul_res;
    end
  end

  always_comb result = last_q;
`endif

  // Outputs gated by RST so a reset drops the drive in the same cycle.
  always_comb begin
    req0_ready   = 1'b0;
    req1_ready   = 1'b0;
    rsp_valid    = 1'b0;
    rsp_id       = 1'b0;
    rsp_data     = '0;
    rsp_timeout  = 1'b0;
    mul_mode     = 1'b0;
    mul_valid_in = 1'b0;
    mul_in1      = '0;
    mul_in2      = '0;
    mul_op       = '0;
    busy         = (state_q != StIdle);
    if (RST) begin
      req0_ready   = (state_q == StIdle) && grant0;
      req1_ready   = (state_q == StIdle) && grant1;
      mul_valid_in = (state_q == StIssue);
      if (busy) begin
        mul_mode = mode_q;
        if (mode_q) begin
          mul_op = bits_q;
        end else begin
          mul_in1 = bits_q[P3:0];
          mul_in2 = bits_q[2*P3+1:P3+1];
        end
      end
      if (state_q == StDone) begin
        rsp_valid   = 1'b1;
        rsp_id      = id_q;
        rsp_timeout = to_q;
        rsp_data    = to_q ? '0 : result;
      end
    end
  end

endmodule

// File: tb/tb_pbit_mul_scheduler.sv
// Randomized bench for pbit_mul_scheduler with a cycle-accurate multiplier stand-in and result model.
module tb_pbit_mul_scheduler;

  localparam int unsigned Window  = 16;
  localparam int unsigned Timeout = 255;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       req0_valid, req1_valid, req0_ready, req1_ready;
  logic       req0_mode, req1_mode;
  logic [3:0] req0_bits, req1_bits;
  logic [7:0] cfg_settle;
  logic       rsp_valid, rsp_id, rsp_timeout;
  logic [3:0] rsp_data;
  logic       mul_mode, mul_valid_in;
  logic [1:0] mul_in1, mul_in2;
  logic [3:0] mul_op, mul_res;
  logic       mul_valid_res;
  logic [18:0] all_out;

  logic [3:0] samp [Window];
  int n_checks = 0;
  int n_pass   = 0;

  pbit_mul_scheduler #(
    .P2(3), .P3(1), .SETTLE_W(8), .WINDOW(Window), .TIMEOUT(Timeout)
  ) dut (
    .CLK(CLK), .RST(RST),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .req0_mode(req0_mode), .req1_mode(req1_mode),
    .req0_bits(req0_bits), .req1_bits(req1_bits),
    .cfg_settle(cfg_settle),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_timeout(rsp_timeout),
    .mul_mode(mul_mode), .mul_valid_in(mul_valid_in),
    .mul_in1(mul_in1), .mul_in2(mul_in2), .mul_op(mul_op),
    .mul_res(mul_res), .mul_valid_res(mul_valid_res)
  );

  assign all_out = {req0_ready, req1_ready, rsp_valid, rsp_id, rsp_data, rsp_timeout,
                    mul_mode, mul_valid_in, mul_in1, mul_in2, mul_op};

  always #5 CLK = ~CLK;

  // Expected response from the window contents.
  function automatic logic [3:0] model_data();
    logic [3:0] d;
`ifdef PBIT_SCHED_VOTE_EN
    for (int b = 0; b < 4; b++) begin
      int cnt;
      cnt = 0;
      for (int s = 0; s < int'(Window); s++) cnt += int'(samp[s][b]);
      d[b] = (2 * cnt > int'(Window));
    end
`else
    d = samp[Window-1];
`endif
    return d;
  endfunction

  task automatic set_req(input bit id, input bit v, input bit m, input logic [3:0] b);
    if (id) begin
      req1_valid = v; req1_mode = m; req1_bits = b;
    end else begin
      req0_valid = v; req0_mode = m; req0_bits = b;
    end
  endtask

  task automatic fill_random();
    for (int i = 0; i < int'(Window); i++) samp[i] = 4'($urandom);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST = 1'b0;
    set_req(1'b0, 1'b0, 1'b0, 4'h0);
    set_req(1'b1, 1'b0, 1'b0, 4'h0);
    mul_valid_res = 1'b0;
    @(negedge CLK);
    RST = 1'b1;
  endtask

  // vdelay: cycles from handshake to first valid_res (<0 = never); rst_at: cycle to pulse reset.
  task automatic job(input bit id, input bit both, input bit mode, input logic [3:0] bits,
                     input logic [7:0] settle, input int vdelay, input bit immediate,
                     input int rst_at, input string name);
    int waited, pulses, pulse_k, rsp_k, exp_k, win0;
    bit drive_ok, ready_ok, spur, quiet;
    logic [1:0] e_in1, e_in2;
    logic [3:0] e_op, e_data, got_data;
    logic got_id, got_to;
    e_in1   = mode ? 2'b00 : bits[1:0];
    e_in2   = mode ? 2'b00 : bits[3:2];
    e_op    = mode ? bits : 4'h0;
    exp_k   = (vdelay < 0) ? int'(Timeout) + 2 : vdelay + int'(settle) + int'(Window) + 1;
    win0    = vdelay + int'(settle) + 1;
    e_data  = (vdelay < 0) ? 4'h0 : model_data();
    spur    = 1'($urandom_range(0, 1));
    pulses  = 0; pulse_k = 0; rsp_k = -1;
    drive_ok = 1'b1; ready_ok = 1'b1;
    got_data = 4'h0; got_id = 1'b0; got_to = 1'b0;

    @(negedge CLK);
    n_checks++;
    if (rsp_valid !== 1'b0) $display("FAIL rsp_pulse_%s: rsp_valid=%b, required 0", name, rsp_valid);
    else n_pass++;
    set_req(id, 1'b1, mode, bits);
    if (both) set_req(!id, 1'b1, 1'($urandom), 4'($urandom));
    else set_req(!id, 1'b0, 1'b0, 4'h0);
    cfg_settle    = settle;
    mul_valid_res = 1'b0;
    #1;
    waited = 0;
    while (!(req0_ready || req1_ready) && waited < 50) begin
      @(negedge CLK);
      if (both) set_req(!id, 1'b1, 1'($urandom), 4'($urandom));
      #1;
      waited++;
    end
    n_checks++;
    if ((id ? req1_ready : req0_ready) !== 1'b1 || (id ? req0_ready : req1_ready) !== 1'b0)
      $display("FAIL grant_%s: ready0=%b ready1=%b, required grant to req%0d",
               name, req0_ready, req1_ready, id);
    else n_pass++;
    if (immediate) begin
      n_checks++;
      if (waited != 0) $display("FAIL next_handshake_%s: waited %0d cycles, required 0", name, waited);
      else n_pass++;
    end

    @(posedge CLK);
    #1;
    if (!both) set_req(id, 1'b0, 1'b0, 4'($urandom));
    cfg_settle = 8'($urandom);

    for (int k = 1; k <= 400 && rsp_k < 0; k++) begin
      @(negedge CLK);
      if (k == rst_at) begin
        RST = 1'b0;
        #1;
        n_checks++;
        if (all_out !== 19'd0) $display("FAIL rst_outputs_%s: outputs=%h, required 0", name, all_out);
        else n_pass++;
        @(posedge CLK);
        @(negedge CLK);
        RST = 1'b1;
        mul_valid_res = 1'b0;
        quiet = 1'b1;
        for (int j = 0; j < 30; j++) begin
          @(negedge CLK);
          if (all_out !== 19'd0) quiet = 1'b0;
        end
        n_checks++;
        if (!quiet) $display("FAIL rst_quiet_%s: activity after reset=%b, required none", name, !quiet);
        else n_pass++;
        return;
      end
      if (mul_valid_in === 1'b1) begin
        pulses++;
        pulse_k = k;
      end
      if ({mul_mode, mul_in2, mul_in1, mul_op} !== {mode, e_in2, e_in1, e_op}) drive_ok = 1'b0;
      if (req0_ready !== 1'b0 || req1_ready !== 1'b0) ready_ok = 1'b0;
      if (rsp_valid === 1'b1) begin
        rsp_k    = k;
        got_data = rsp_data;
        got_id   = rsp_id;
        got_to   = rsp_timeout;
      end else begin
        mul_valid_res = (k == vdelay) || (spur && vdelay > 0 && (k == 1 || k > vdelay));
        mul_res = (vdelay >= 0 && k >= win0 && k < win0 + int'(Window)) ? samp[k-win0]
                                                                       : 4'($urandom);
        if (both) set_req(!id, 1'b1, 1'($urandom), 4'($urandom));
      end
    end
    mul_valid_res = 1'b0;

    n_checks++;
    if (pulses != 1 || pulse_k != 1)
      $display("FAIL valid_in_%s: %0d pulses last at +%0d, required 1 pulse at +1",
               name, pulses, pulse_k);
    else n_pass++;
    n_checks++;
    if (!drive_ok) $display("FAIL drive_%s: held drive=%b, required mode=%b in2=%b in1=%b op=%h",
                            name, drive_ok, mode, e_in2, e_in1, e_op);
    else n_pass++;
    n_checks++;
    if (!ready_ok) $display("FAIL busy_ready_%s: ready seen while busy=%b, required 0", name, !ready_ok);
    else n_pass++;
    n_checks++;
    if (rsp_k != exp_k) $display("FAIL latency_%s: rsp at +%0d, required +%0d", name, rsp_k, exp_k);
    else n_pass++;
    n_checks++;
    if (got_id !== id) $display("FAIL rsp_id_%s: %b, required %b", name, got_id, id);
    else n_pass++;
    n_checks++;
    if (got_data !== e_data) $display("FAIL rsp_data_%s: %h, required %h", name, got_data, e_data);
    else n_pass++;
    n_checks++;
    if (got_to !== (vdelay < 0))
      $display("FAIL rsp_timeout_%s: %b, required %b", name, got_to, (vdelay < 0));
    else n_pass++;
  endtask

  task automatic test_reset();
    RST = 1'b0;
    set_req(1'b0, 1'b1, 1'b0, 4'($urandom));
    set_req(1'b1, 1'b1, 1'b1, 4'($urandom));
    mul_valid_res = 1'b1;
    mul_res = 4'hf;
    repeat (3) @(negedge CLK);
    n_checks++;
    if (all_out !== 19'd0) $display("FAIL reset_held: outputs=%h, required 0", all_out);
    else n_pass++;
    RST = 1'b1;
    set_req(1'b0, 1'b0, 1'b0, 4'h0);
    set_req(1'b1, 1'b0, 1'b0, 4'h0);
    mul_valid_res = 1'b0;
    @(negedge CLK);
    n_checks++;
    if (all_out !== 19'd0) $display("FAIL reset_idle: outputs=%h, required 0", all_out);
    else n_pass++;
  endtask

  task automatic test_forward();
    for (int i = 0; i < int'(Window); i++) samp[i] = 4'h6;
    job(1'b0, 1'b0, 1'b0, 4'he, 8'd0, 4, 1'b0, 0, "forward");
  endtask

  task automatic test_contention();
    bit last, nxt;
    do_reset();
    last = 1'b1;
    for (int j = 0; j < 4; j++) begin
      fill_random();
      nxt = !last;
      job(nxt, 1'b1, 1'($urandom), 4'($urandom), 8'($urandom_range(0, 3)),
          int'($urandom_range(2, 5)), (j > 0), 0, "contention");
      last = nxt;
    end
    set_req(1'b0, 1'b0, 1'b0, 4'h0);
    set_req(1'b1, 1'b0, 1'b0, 4'h0);
  endtask

  task automatic test_timeout();
    job(1'b0, 1'b0, 1'($urandom), 4'($urandom), 8'($urandom_range(0, 9)), -1, 1'b0, 0, "timeout");
    fill_random();
    job(1'b1, 1'b0, 1'b0, 4'($urandom), 8'd2, 3, 1'b0, 0, "after_timeout");
  endtask

  task automatic test_vote();
    for (int i = 0; i < int'(Window); i++) samp[i] = (i % 3 == 0) ? 4'h2 : 4'h6;
    job(1'b0, 1'b0, 1'b0, 4'h9, 8'd0, 2, 1'b0, 0, "vote_10_6");
    for (int i = 0; i < int'(Window); i++) samp[i] = (i % 2 == 0) ? 4'h2 : 4'h6;
    job(1'b1, 1'b0, 1'b1, 4'h6, 8'd1, 3, 1'b0, 0, "vote_tie");
  endtask

  task automatic test_settle_mode1();
    fill_random();
    job(1'b1, 1'b0, 1'b1, 4'h4, 8'd5, 4, 1'b0, 0, "settle_mode1");
    fill_random();
    job(1'b1, 1'b0, 1'b1, 4'h4, 8'd0, 4, 1'b0, 0, "nosettle_mode1");
  endtask

  task automatic test_random();
    for (int j = 0; j < 6; j++) begin
      fill_random();
      job(1'($urandom), 1'b0, 1'($urandom), 4'($urandom), 8'($urandom_range(0, 6)),
          int'($urandom_range(2, 8)), 1'b0, 0, "random");
    end
  endtask

  task automatic test_reset_in_sample();
    fill_random();
    job(1'b0, 1'b0, 1'b0, 4'($urandom), 8'd0, 3, 1'b0, 9, "rst_sample");
    fill_random();
    job(1'b0, 1'b0, 1'b0, 4'($urandom), 8'($urandom_range(0, 4)), 2, 1'b0, 0, "after_rst");
  endtask

  initial begin
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_mode = 1'b0; req1_mode = 1'b0;
    req0_bits = 4'h0; req1_bits = 4'h0;
    cfg_settle = 8'd0;
    mul_res = 4'h0;
    mul_valid_res = 1'b0;
    test_reset();
    test_forward();
    test_contention();
    test_timeout();
    test_vote();
    test_settle_mode1();
    test_random();
    test_reset_in_sample();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
